// File: rtl/fir_output_decimator.sv
// Output stage of a FIR filter: discards pipeline-fill samples, decimates,
// rounds and saturates the full-precision result, and buffers it in a show-ahead FIFO.
module fir_output_decimator #(
  parameter int IN_WIDTH    = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 15,
  parameter int DECIM       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILL_CYCLES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic signed [IN_WIDTH-1:0]  i_data,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_overflow,
  output logic                        o_sat,
  input  logic                        i_clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(FILL_CYCLES + 1);
  localparam int SW = IN_WIDTH + 1;

  localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_CYCLES - 1);
  localparam logic [PW-1:0] DECIM_LAST = PW'(DECIM - 1);
  localparam logic signed [SW-1:0] RND_ADD =
    {{(SW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_keep;
  logic [CW-1:0]          r_fill_cnt;
  logic [PW-1:0]          r_phase;

  logic                   r_s1_valid;
  logic signed [SW-1:0]   r_s1_sum;
  logic signed [SW-1:0]   w_shifted;
  logic [OUT_WIDTH-1:0]   w_sat_data;
  logic                   w_sat_flag;
  logic                   r_s2_valid;
  logic [OUT_WIDTH-1:0]   r_s2_data;
  logic                   r_s2_sat;

  logic [OUT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_write;
  logic                   w_drop;
  logic                   r_ovf;
  logic                   r_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_keep      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (r_fill_cnt == FILL_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
        w_keep      = (r_phase == {PW{1'b0}});
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // Fill counter only advances in FILL; the phase counter only in RUN, so the
  // first RUN sample lands on phase 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill_cnt <= {CW{1'b0}};
      r_phase    <= {PW{1'b0}};
    end else if (r_state == S_FILL) begin
      if (r_fill_cnt != FILL_LAST) begin
        r_fill_cnt <= r_fill_cnt + CW'(1);
      end
    end else if (r_phase == DECIM_LAST) begin
      r_phase <= {PW{1'b0}};
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= {SW{1'b0}};
    end else begin
      r_s1_valid <= w_keep;
      if (w_keep) begin
        r_s1_sum <= {i_data[IN_WIDTH-1], i_data} + RND_ADD;
      end
    end
  end

  always_comb begin
    w_shifted  = r_s1_sum >>> SHIFT;
    w_sat_data = w_shifted[OUT_WIDTH-1:0];
    w_sat_flag = 1'b0;
    if (w_shifted > SAT_MAX) begin
      w_sat_data = SAT_MAX[OUT_WIDTH-1:0];
      w_sat_flag = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_sat_data = SAT_MIN[OUT_WIDTH-1:0];
      w_sat_flag = 1'b1;
    end else begin
      w_sat_flag = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {OUT_WIDTH{1'b0}};
      r_s2_sat   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_sat_data;
      r_s2_sat   <= w_sat_flag;
    end
  end

  // Extra pointer MSB separates full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  assign w_write = r_s2_valid && (!w_full || w_pop);
  assign w_drop  = r_s2_valid && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_wptr[AW-1:0]] <= r_s2_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
      r_ovf  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
      r_sat <= w_write && r_s2_sat;
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? {OUT_WIDTH{1'b0}} : r_mem[r_rptr[AW-1:0]];
  assign o_overflow = r_ovf;
  assign o_sat      = r_sat;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Scoreboard bench: a DECIM=4 instance for fill/decimation/backpressure/reset and
// a DECIM=1 instance for rounding and saturation.
module tb_fir_output_decimator;

  logic               clk;
  logic               rst_n;
  logic signed [47:0] d4, d1;
  logic               r4;
  logic               r1;
  logic               clr4;
  logic               clr1;
  logic signed [15:0] od4, od1;
  logic               v4, v1, ov4, ov1, s4, s1;

  int          n_vec;
  int          n_err;
  int          e;
  logic [16:0] q4[$];
  logic [16:0] q1[$];
  logic [16:0] m4, m1;

  fir_output_decimator u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d4), .o_data(od4), .o_valid(v4),
    .i_ready(r4), .o_overflow(ov4), .o_sat(s4), .i_clr_ovf(clr4)
  );

  fir_output_decimator #(.DECIM(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .o_data(od1), .o_valid(v1),
    .i_ready(r1), .o_overflow(ov1), .o_sat(s1), .i_clr_ovf(clr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: round half up at 2^15, then clamp to 16-bit signed.
  function automatic logic [16:0] model(input longint x);
    longint r;
    logic   sat;
    r   = (x + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (r > 64'sd32767) begin
      r   = 64'sd32767;
      sat = 1'b1;
    end else if (r < -64'sd32768) begin
      r   = -64'sd32768;
      sat = 1'b1;
    end
    return {sat, r[15:0]};
  endfunction

  // Pops are predicted from the inputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v4 && r4) begin
        if (q4.size() == 0) begin
          chk("dut4_spurious_valid", 64'(v4), 64'sd0);
        end else begin
          m4 = q4.pop_front();
          chk("dut4_data", 64'(od4), 64'($signed(m4[15:0])));
        end
      end
      if (v1 && r1) begin
        if (q1.size() == 0) begin
          chk("dut1_spurious_valid", 64'(v1), 64'sd0);
        end else begin
          m1 = q1.pop_front();
          chk("dut1_data", 64'(od1), 64'($signed(m1[15:0])));
          chk("dut1_sat", 64'(s1), 64'(m1[16]));
        end
      end
    end
  end

  task automatic step(input longint x4, input logic rdy, input longint x1, input logic drop);
    d4 = x4[47:0];
    d1 = x1[47:0];
    r4 = rdy;
    if (e >= 64) begin
      if (((e - 64) % 4 == 0) && !drop) q4.push_back(model(x4));
      q1.push_back(model(x1));
    end
    @(posedge clk);
    #2;
    e++;
  endtask

  task automatic fill_checks();
    if (e - 1 <= 65) chk("fill_no_valid", 64'(v4), 64'sd0);
    if (e - 1 == 66) chk("first_valid", 64'(v4), 64'sd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid4", 64'(v4), 64'sd0);
    chk("rst_data4", 64'(od4), 64'sd0);
    chk("rst_ovf4", 64'(ov4), 64'sd0);
    chk("rst_sat4", 64'(s4), 64'sd0);
    chk("rst_valid1", 64'(v1), 64'sd0);
    chk("rst_sat1", 64'(s1), 64'sd0);
    q4.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    e = 0;
  endtask

  longint vec[8];
  longint ramp;

  initial begin
    rst_n = 1'b1; d4 = 48'sd0; d1 = 48'sd0; r4 = 1'b1; r1 = 1'b1;
    clr4 = 1'b0; clr1 = 1'b0; n_vec = 0; n_err = 0; e = 0;
    vec = '{64'sd16384, 64'sd16383, -64'sd16384, -64'sd16385, 64'sd3276800,
            64'sd1099511627776, -64'sd1099511627776, 64'sd1073709056};
    #2;

    // Fill latency on DUT4, rounding/saturation table on DUT1.
    do_reset();
    for (int i = 0; i < 96; i++) begin
      step(64'sd32768, 1'b1, (e >= 64 && e < 72) ? vec[e-64] : 64'sd0, 1'b0);
      fill_checks();
    end
    chk("a_drain", 64'(q4.size()), 64'sd0);

    // Post-fill ramp: decimated outputs 0,4,8,...
    do_reset();
    for (int i = 0; i < 108; i++) begin
      ramp = (e >= 64) ? longint'(e - 64) * 64'sd32768 : 64'sd0;
      step(ramp, 1'b1, 64'sd0, 1'b0);
    end
    chk("b_drain", 64'(q4.size()), 64'sd0);

    // Backpressure: kept samples from edge 96 to 120 arrive at a full FIFO.
    do_reset();
    for (int i = 0; i < 140; i++) begin
      ramp = (e >= 64) ? longint'(e - 64) * 64'sd32768 : 64'sd0;
      step(ramp, !(e >= 64 && e <= 123), 64'sd0, (e >= 96 && e <= 120));
      if (e - 1 == 123) begin
        chk("c_ovf_set", 64'(ov4), 64'sd1);
        chk("c_held_valid", 64'(v4), 64'sd1);
      end
    end
    chk("c_drain", 64'(q4.size()), 64'sd0);
    chk("c_ovf_sticky", 64'(ov4), 64'sd1);
    clr4 = 1'b1;
    ramp = longint'(e - 64) * 64'sd32768;
    step(ramp, 1'b1, 64'sd0, 1'b0);
    clr4 = 1'b0;
    chk("c_ovf_clr", 64'(ov4), 64'sd0);

    // Mid-run reset with five entries queued, then a full refill.
    do_reset();
    for (int i = 0; i < 84; i++) begin
      step(64'sd32768, (e < 64), 64'sd0, 1'b0);
    end
    chk("d_queued_valid", 64'(v4), 64'sd1);
    do_reset();
    for (int i = 0; i < 68; i++) begin
      step(64'sd32768, 1'b1, 64'sd0, 1'b0);
      fill_checks();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
